io_request_arbiter: RTL and testbench
=====================================

# io_request_arbiter

Arbitrates non-cacheable I/O requests from all processor cores onto the single shared I/O bus. It grants one request per cycle and drives the external I/O read/write strobes, address and data. It returns a one-cycle-delayed response, tagged with core and thread, that is broadcast to every core. It sits at the top level between the cores' I/O request ports and the external device/peripheral interface.

## Interface
Parameters:
- NUM_CORES, default `NUM_CORES (1–16): number of requesting cores.
- CORE_ID_WIDTH, default 4: width of the core tag in responses.
- THREAD_IDX_WIDTH, default 2: width of the thread tag.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_request[NUM_CORES]  in  ioreq_packet_t  per core: valid, store, thread_idx, address[31:0], value[31:0]; held stable until granted.
- ia_ready[NUM_CORES]  out  1 each  grant/accept strobe to the requesting core.
- ia_response  out  iorsp_packet_t  valid, core, thread_idx, read_value[31:0]; broadcast to all cores.
- io_write_en  out  1  external write strobe.
- io_read_en  out  1  external read strobe.
- io_address  out  32  external address.
- io_write_data  out  32  external write data.
- io_read_data  in  32  external read data, valid the cycle after io_read_en.

## Operation
- Each cycle, a round-robin arbiter selects one core among those with io_request[i].valid=1.
- ia_ready[i]=1 only for the granted core (one-hot or zero). A request is consumed in the grant cycle. The core must drop or replace valid the next cycle.
- Granted request drives the bus combinationally in the same cycle:
  - io_write_en = grant & store
  - io_read_en = grant & !store
  - io_address = request address
  - io_write_data = request value
- With no grant: both strobes are 0, and address/data are don't-care (drive the core-0 values).
- Response register, loaded every cycle:
  - valid ← any grant
  - core ← granted index
  - thread_idx ← granted thread_idx
- ia_response.read_value = io_read_data combinationally during the response cycle.
- Stores also produce a response (acknowledge); read_value is don't-care for stores.
- The external device never stalls; there is no backpressure.
- Round-robin rules:
  - The priority pointer advances to (granted index + 1) mod NUM_CORES after each grant.
  - The pointer is unchanged when there is no grant.
  - Index wrap-around uses mod NUM_CORES.
- NUM_CORES=1: the arbiter degenerates to a pass-through; ia_ready = valid.

## Timing
- Grant and strobes: 0 cycles (combinational from io_request).
- Response: exactly 1 cycle after grant. Back-to-back grants produce back-to-back responses.
- Reset (asynchronous assert, low):
  - ia_response.valid=0, core=0, thread_idx=0.
  - Priority pointer at core 0.
  - ia_ready and strobes follow requests combinationally; requesters are expected idle during reset.
- Reset mid-operation: a pending response is dropped (valid→0). The first grant after release favours core 0.
- Simultaneous requests from all cores: each is served once within NUM_CORES consecutive cycles; no core waits longer than NUM_CORES-1 cycles.

## Structure
- ioreq_packet_t and iorsp_packet_t belong in the shared defines package, along with core_id_t, thread_idx_t, scalar_t and `NUM_CORES.
- One sub-module: rr_arbiter, parameterized by NUM_REQUESTERS.
  - Inputs: request vector, update_lru.
  - Outputs: one-hot grant.
  - Reused elsewhere in the design.
- Remaining logic: one-hot→index encoder, grant mux, response register.

## Test plan
- Single read: core 0 reads 0x60 (thread 2), device returns 0xDEADBEEF next cycle.
  - Same cycle: io_read_en=1, io_address=0x60, ia_ready[0]=1.
  - Next cycle: ia_response={valid=1, core=0, thread=2, read_value=0xDEADBEEF}.
- Single write: core 1 stores 0x5 to 0x64.
  - Same cycle: io_write_en=1, io_write_data=0x5, io_read_en=0.
  - Next cycle: response valid=1, core=1.
- Contention: 4 cores request continuously.
  - Grants go 0,1,2,3,0.
  - Each ia_ready is one-hot.
  - Responses follow one cycle later with matching core and thread tags.
- Idle: no requests.
  - Strobes are 0 and all ia_ready are 0.
  - Next-cycle ia_response.valid=0; the pointer does not move.
- Async reset: assert reset low mid-stream with a response pending.
  - ia_response.valid=0 immediately.
  - After release, with cores 2 and 0 requesting, core 0 is granted first.

Source files
------------

// File: rtl/io_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_request_arbiter_pkg
//  Description : Shared definitions for the I/O request path: core/thread
//                tag types, the 32-bit scalar type and the request/response
//                packets exchanged between the cores and the I/O arbiter.
//                Also provides the default core count macro.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_request_arbiter_pkg;

    localparam int c_CORE_ID_WIDTH    = 4;
    localparam int c_THREAD_IDX_WIDTH = 2;

    typedef logic [c_CORE_ID_WIDTH-1:0]    core_id_t;
    typedef logic [c_THREAD_IDX_WIDTH-1:0] thread_idx_t;
    typedef logic [31:0]                   scalar_t;

    // Non-cacheable request from one core; held stable until granted.
    typedef struct packed {
        logic        valid;
        logic        store;
        thread_idx_t thread_idx;
        scalar_t     address;
        scalar_t     value;
    } ioreq_packet_t;

    // Response broadcast to every core one cycle after the grant.
    typedef struct packed {
        logic        valid;
        core_id_t    core;
        thread_idx_t thread_idx;
        scalar_t     read_value;
    } iorsp_packet_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter producing a one-hot grant. The search
//                starts at the priority pointer; when update_lru is high and
//                a grant is made, the pointer moves to the slot just after
//                the granted requester. With a single requester the grant
//                is a pass-through of the request.
//  Ports       : clk, reset (async, active-low), request[N], update_lru,
//                grant_oh[N] (one-hot or zero)
//  Revision    : 1.0 - initial release
// ============================================================================

module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    generate
        if (NUM_REQUESTERS == 1) begin : g_single
            assign grant_oh = request;
        end else begin : g_multi
            localparam int                 c_PTR_W = $clog2(NUM_REQUESTERS);
            localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQUESTERS - 1);
            localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

            logic [c_PTR_W-1:0]        r_ptr;
            logic [c_PTR_W-1:0]        w_idx;
            logic [c_PTR_W-1:0]        w_gidx;
            logic                      w_found;
            logic [NUM_REQUESTERS-1:0] w_grant;

            // Walk the requesters starting at the pointer; the first
            // active one wins.
            always_comb begin
                w_grant = '0;
                w_found = 1'b0;
                w_gidx  = '0;
                w_idx   = '0;
                for (int k = 0; k < NUM_REQUESTERS; k++) begin
                    w_idx = c_PTR_W'((int'(r_ptr) + k) % NUM_REQUESTERS);
                    if (!w_found && request[w_idx]) begin
                        w_grant[w_idx] = 1'b1;
                        w_found        = 1'b1;
                        w_gidx         = w_idx;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_ptr <= '0;
                end else if (update_lru && w_found) begin
                    r_ptr <= (w_gidx == c_LAST) ? '0 : w_gidx + c_ONE;
                end
            end

            assign grant_oh = w_grant;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/io_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_request_arbiter
//  Description : Arbitrates non-cacheable I/O requests from all cores onto
//                the single external I/O bus, one grant per cycle. The
//                granted request drives the bus strobes, address and data
//                combinationally; a tagged response is registered and
//                broadcast to every core on the following cycle, with the
//                read data passed straight through from the device.
//  Ports       : clk, reset (async, active-low)
//                io_request[NUM_CORES] -> ia_ready[NUM_CORES] (grant)
//                ia_response (valid/core/thread/read_value)
//                io_write_en, io_read_en, io_address, io_write_data,
//                io_read_data
//  Revision    : 1.0 - initial release
// ============================================================================

module io_request_arbiter
    import io_request_arbiter_pkg::*;
#(
    parameter int NUM_CORES        = `NUM_CORES,
    parameter int CORE_ID_WIDTH    = 4,
    parameter int THREAD_IDX_WIDTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  ioreq_packet_t  io_request [NUM_CORES],
    output logic [NUM_CORES-1:0] ia_ready,
    output iorsp_packet_t  ia_response,
    output logic           io_write_en,
    output logic           io_read_en,
    output logic [31:0]    io_address,
    output logic [31:0]    io_write_data,
    input  logic [31:0]    io_read_data
);

    logic [NUM_CORES-1:0]        w_req_valid;
    logic [NUM_CORES-1:0]        w_grant;
    logic                        w_any_grant;
    logic [CORE_ID_WIDTH-1:0]    w_grant_idx;
    ioreq_packet_t               w_sel_req;
    logic                        w_bus_active;

    logic                        r_rsp_valid;
    logic [CORE_ID_WIDTH-1:0]    r_rsp_core;
    logic [THREAD_IDX_WIDTH-1:0] r_rsp_thread;

    always_comb begin
        w_req_valid = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_req_valid[i] = io_request[i].valid;
        end
    end

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_CORES)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .request    (w_req_valid),
        .update_lru (w_any_grant),
        .grant_oh   (w_grant)
    );

    assign w_any_grant = |w_grant;
    assign ia_ready    = w_grant;

    // One-hot to index; grant is one-hot so OR-ing the indices is exact.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = w_grant_idx | CORE_ID_WIDTH'(i);
            end
        end
    end

    // Grant mux; with no grant the core-0 request sits on the bus.
    always_comb begin
        w_sel_req = io_request[0];
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant[i]) begin
                w_sel_req = io_request[i];
            end
        end
    end

    assign w_bus_active  = w_any_grant & w_sel_req.valid;
    assign io_write_en   = w_bus_active &  w_sel_req.store;
    assign io_read_en    = w_bus_active & ~w_sel_req.store;
    assign io_address    = w_sel_req.address;
    assign io_write_data = w_sel_req.value;

    // Response tag register, reloaded every cycle so an idle cycle
    // clears the valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_core   <= '0;
            r_rsp_thread <= '0;
        end else begin
            r_rsp_valid  <= w_any_grant;
            r_rsp_core   <= w_grant_idx;
            r_rsp_thread <= THREAD_IDX_WIDTH'(w_sel_req.thread_idx);
        end
    end

    always_comb begin
        ia_response            = '0;
        ia_response.valid      = r_rsp_valid;
        ia_response.core       = core_id_t'(r_rsp_core);
        ia_response.thread_idx = thread_idx_t'(r_rsp_thread);
        ia_response.read_value = io_read_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_io_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_request_arbiter
//  Description : Self-checking bench for io_request_arbiter. Directed steps
//                (single read, single write, idle, async reset, contention)
//                followed by randomized request traffic, all compared with
//                a behavioural round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

module tb_io_request_arbiter;
    import io_request_arbiter_pkg::*;

    localparam int N = `NUM_CORES;

    logic          clk;
    logic          reset;
    ioreq_packet_t req [N];
    logic [N-1:0]  ia_ready;
    iorsp_packet_t ia_response;
    logic          io_write_en;
    logic          io_read_en;
    logic [31:0]   io_address;
    logic [31:0]   io_write_data;
    logic [31:0]   io_read_data;

    int vectors;
    int miscompares;

    // Reference model state
    int ptr;
    bit prev_valid;
    int prev_core;
    int prev_thread;
    bit prev_store;
    int last_g;

    io_request_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .io_request    (req),
        .ia_ready      (ia_ready),
        .ia_response   (ia_response),
        .io_write_en   (io_write_en),
        .io_read_en    (io_read_en),
        .io_address    (io_address),
        .io_write_data (io_write_data),
        .io_read_data  (io_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) req[i] = '0;
    endtask

    // Called at posedge+1 with inputs driven: waits to mid-cycle, checks
    // every output against the model, then advances the model.
    // dir >= 0 : grant must go to that core; dir == -1 : no grant;
    // dir == -2 : no directed expectation.
    task automatic eval(input int dir);
        int g;
        #4;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req[(ptr + k) % N].valid) g = (ptr + k) % N;
        end
        check("ia_ready", 64'(ia_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (dir != -2)
            check("dir_grant", 64'(ia_ready), (dir < 0) ? 64'd0 : (64'd1 << dir));
        check("io_write_en", 64'(io_write_en), (g >= 0 && req[g].store) ? 64'd1 : 64'd0);
        check("io_read_en", 64'(io_read_en), (g >= 0 && !req[g].store) ? 64'd1 : 64'd0);
        if (g >= 0) begin
            check("io_address", 64'(io_address), 64'(req[g].address));
            if (req[g].store) check("io_write_data", 64'(io_write_data), 64'(req[g].value));
        end
        check("rsp_valid", 64'(ia_response.valid), 64'(prev_valid));
        if (prev_valid) begin
            check("rsp_core", 64'(ia_response.core), 64'(prev_core));
            check("rsp_thread", 64'(ia_response.thread_idx), 64'(prev_thread));
            if (!prev_store) check("rsp_read_value", 64'(ia_response.read_value), 64'(io_read_data));
        end
        prev_valid = (g >= 0);
        if (g >= 0) begin
            ptr         = (g + 1) % N;
            prev_core   = g;
            prev_thread = int'(req[g].thread_idx);
            prev_store  = req[g].store;
        end
        last_g = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ptr        = 0;
        prev_valid = 0;
    endtask

    initial begin
        int order [5];
        vectors     = 0;
        miscompares = 0;
        ptr = 0; prev_valid = 0; prev_core = 0; prev_thread = 0; prev_store = 0; last_g = -1;
        reset        = 1'b0;
        io_read_data = 32'h0;
        clear_reqs();

        // Reset state
        tick();
        eval(-1);
        check("reset_core", 64'(ia_response.core), 64'd0);
        check("reset_thread", 64'(ia_response.thread_idx), 64'd0);
        reset = 1'b1;
        tick();

        // Single read: core 0, thread 2, address 0x60
        req[0] = '{valid: 1'b1, store: 1'b0, thread_idx: 2'd2, address: 32'h60, value: 32'h0};
        eval(0);
        check("rd_address", 64'(io_address), 64'h60);
        check("rd_read_en", 64'(io_read_en), 64'd1);
        tick();
        clear_reqs();
        io_read_data = 32'hDEADBEEF;
        eval(-1);
        check("rd_rsp_valid", 64'(ia_response.valid), 64'd1);
        check("rd_rsp_core", 64'(ia_response.core), 64'd0);
        check("rd_rsp_thread", 64'(ia_response.thread_idx), 64'd2);
        check("rd_rsp_value", 64'(ia_response.read_value), 64'hDEADBEEF);
        tick();

        // Single write: core 1 stores 0x5 to 0x64
        req[1] = '{valid: 1'b1, store: 1'b1, thread_idx: 2'd1, address: 32'h64, value: 32'h5};
        eval(1);
        check("wr_write_en", 64'(io_write_en), 64'd1);
        check("wr_read_en", 64'(io_read_en), 64'd0);
        check("wr_data", 64'(io_write_data), 64'h5);
        tick();
        clear_reqs();
        eval(-1);
        check("wr_rsp_valid", 64'(ia_response.valid), 64'd1);
        check("wr_rsp_core", 64'(ia_response.core), 64'd1);
        tick();

        // Idle: nothing granted, response drops, pointer holds (next
        // single request from core 3 then core 2 checks pointer at 2).
        eval(-1);
        tick();
        eval(-1);
        check("idle_rsp_valid", 64'(ia_response.valid), 64'd0);
        tick();
        req[3].valid = 1'b1; req[2].valid = 1'b1;
        eval(2);
        tick();

        // Async reset with a response pending
        clear_reqs();
        req[1] = '{valid: 1'b1, store: 1'b0, thread_idx: 2'd3, address: 32'h80, value: 32'h0};
        eval(1);
        tick();
        clear_reqs();
        #1;
        reset = 1'b0;
        #1;
        check("async_rsp_valid", 64'(ia_response.valid), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        eval(-1);
        tick();
        reset = 1'b1;
        req[2] = '{valid: 1'b1, store: 1'b0, thread_idx: 2'd1, address: 32'h200, value: 32'h0};
        req[0] = '{valid: 1'b1, store: 1'b1, thread_idx: 2'd0, address: 32'h100, value: 32'h7};
        eval(0);
        tick();
        clear_reqs();

        // Contention from a fresh reset: all cores request continuously
        reset = 1'b0;
        model_reset();
        tick();
        eval(-1);
        reset = 1'b1;
        tick();
        for (int i = 0; i < N; i++)
            req[i] = '{valid: 1'b1, store: 1'b0, thread_idx: 2'(i), address: 32'h1000 + 32'(i),
                       value: 32'h0};
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            io_read_data = $urandom();
            eval(order[k] % N);
            tick();
        end
        clear_reqs();

        // Randomized traffic honouring hold-until-granted
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i].valid || last_g == i) begin
                    req[i].valid      = ($urandom_range(0, 2) != 0);
                    req[i].store      = 1'($urandom_range(0, 1));
                    req[i].thread_idx = 2'($urandom_range(0, 3));
                    req[i].address    = $urandom();
                    req[i].value      = $urandom();
                end
            end
            io_read_data = $urandom();
            eval(-2);
            tick();
        end
        clear_reqs();
        eval(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
